// File: rtl/key_cmd_decoder.sv
// PS/2 keyboard command decoder: parses make/break/extended byte sequences,
// tracks held keys and queues game commands in a small registered FIFO.
module key_cmd_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [3:0]               cmd_code,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     any_make,
  output logic [8:0]               held,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK} state_t;

  function automatic logic [3:0] map_code(input logic [7:0] b);
    logic [3:0] c;
    case (b)
      8'h6B, 8'h1C: c = 4'd1;
      8'h74, 8'h23: c = 4'd2;
      8'h75, 8'h1D: c = 4'd3;
      8'h72, 8'h1B: c = 4'd4;
      8'h29:        c = 4'd5;
      8'h2D:        c = 4'd6;
      8'h16:        c = 4'd7;
      8'h1E:        c = 4'd8;
      8'h26:        c = 4'd9;
      default:      c = 4'd0;
    endcase
    return c;
  endfunction

  function automatic logic [8:0] code_mask(input logic [3:0] c);
    logic [8:0] m;
    case (c)
      4'd1:    m = 9'b0_0000_0001;
      4'd2:    m = 9'b0_0000_0010;
      4'd3:    m = 9'b0_0000_0100;
      4'd4:    m = 9'b0_0000_1000;
      4'd5:    m = 9'b0_0001_0000;
      4'd6:    m = 9'b0_0010_0000;
      4'd7:    m = 9'b0_0100_0000;
      4'd8:    m = 9'b0_1000_0000;
      4'd9:    m = 9'b1_0000_0000;
      default: m = 9'b0_0000_0000;
    endcase
    return m;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [3:0]      cmd_code_q, cmd_code_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            any_make_q, any_make_d;
  logic [8:0]      held_q, held_d;
  logic            overflow_q, overflow_d;

  logic            make_s, brk_s, mapped_s, already_s, new_key_s;
  logic            pop_s, push_s, full_s, drop_s;
  logic [3:0]      code_s;
  logic [8:0]      mask_s;

  // Parser next-state and make/break event detection.
  always_comb begin
    state_d = state_q;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == 8'hE0)      state_d = S_EXT;
          else if (rx_byte == 8'hF0) state_d = S_BRK;
          else                       make_s  = 1'b1;
        end
        S_EXT: begin
          if (rx_byte == 8'hE0)      state_d = S_EXT;
          else if (rx_byte == 8'hF0) state_d = S_BRK;
          else begin
            make_s  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if ((rx_byte == 8'hE0) || (rx_byte == 8'hF0)) begin
            state_d = S_BRK;
          end else begin
            brk_s   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Held-key tracking, FIFO control and next values of every registered output.
  always_comb begin
    code_s    = map_code(rx_byte);
    mask_s    = code_mask(code_s);
    mapped_s  = (code_s != 4'd0);
    already_s = ((held_q & mask_s) != 9'd0);
    new_key_s = make_s && mapped_s && !already_s;
    pop_s     = cmd_valid_q && cmd_ready;
    full_s    = (count_q == LW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_s    = new_key_s && (!full_s || pop_s);
    drop_s    = new_key_s && full_s && !pop_s;

    if (new_key_s) begin
      held_d = held_q | mask_s;
    end else if (brk_s && mapped_s) begin
      held_d = held_q & ~mask_s;
    end else begin
      held_d = held_q;
    end

    any_make_d = make_s && (!mapped_s || !already_s);
    overflow_d = overflow_q || drop_s;

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = code_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end

    wr_ptr_d = wr_ptr_q + PW'(push_s);
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    count_d  = count_q + LW'(push_s) - LW'(pop_s);

    // Head is taken from the post-write memory so a push into an empty FIFO is visible at once.
    if (count_d == LW'(0)) begin
      cmd_valid_d = 1'b0;
      cmd_code_d  = 4'd0;
    end else begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = mem_d[rd_ptr_d];
    end
  end

  // State register; reset wins over any same-cycle byte or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
      rd_ptr_q    <= PW'(0);
      wr_ptr_q    <= PW'(0);
      count_q     <= LW'(0);
      cmd_code_q  <= 4'd0;
      cmd_valid_q <= 1'b0;
      any_make_q  <= 1'b0;
      held_q      <= 9'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      cmd_code_q  <= cmd_code_d;
      cmd_valid_q <= cmd_valid_d;
      any_make_q  <= any_make_d;
      held_q      <= held_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cmd_code  = cmd_code_q;
  assign cmd_valid = cmd_valid_q;
  assign any_make  = any_make_q;
  assign held      = held_q;
  assign level     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed, table-driven bench for key_cmd_decoder (DEPTH=4) with a
// hand-written pointer-wrap sequence.
module tb_key_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [3:0] cmd_code;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       any_make;
  logic [8:0] held;
  logic [2:0] level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  key_cmd_decoder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cmd_code(cmd_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .any_make(any_make), .held(held), .level(level), .overflow(overflow)
  );

  always #10 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic [7:0] b;
    logic       rdy;
    logic [3:0] code;
    logic       valid;
    logic       any;
    logic [8:0] held;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rst, input logic vld, input logic [7:0] b,
                     input logic rdy, input logic [3:0] code, input logic valid, input logic any,
                     input logic [8:0] hd, input logic [2:0] lvl, input logic ovf);
    vec_t v;
    v.name = nm; v.rst = rst; v.vld = vld; v.b = b; v.rdy = rdy;
    v.code = code; v.valid = valid; v.any = any; v.held = hd; v.lvl = lvl; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {code,valid,any,held,level,ovf}=%h, expected %h", nm, act, exp);
    end
  endtask

  logic [7:0] keys  [3] = '{8'h16, 8'h1E, 8'h26};
  logic [3:0] codes [3] = '{4'd7, 4'd8, 4'd9};

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;

    //   name          rst  vld  byte   rdy  code valid any held     lvl   ovf
    add("reset",       1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("030_1c",      1'b0, 1'b1, 8'h1C, 1'b0, 4'd1, 1'b1, 1'b1, 9'h001, 3'd1, 1'b0);
    add("030_rep",     1'b0, 1'b1, 8'h1C, 1'b0, 4'd1, 1'b1, 1'b0, 9'h001, 3'd1, 1'b0);
    add("030_f0",      1'b0, 1'b1, 8'hF0, 1'b0, 4'd1, 1'b1, 1'b0, 9'h001, 3'd1, 1'b0);
    add("030_brk",     1'b0, 1'b1, 8'h1C, 1'b0, 4'd1, 1'b1, 1'b0, 9'h000, 3'd1, 1'b0);
    add("030_remake",  1'b0, 1'b1, 8'h1C, 1'b0, 4'd1, 1'b1, 1'b1, 9'h001, 3'd2, 1'b0);
    add("030_pop1",    1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b1, 1'b0, 9'h001, 3'd1, 1'b0);
    add("030_pop2",    1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 9'h001, 3'd0, 1'b0);
    add("pop_empty",   1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 9'h001, 3'd0, 1'b0);
    add("rst_a",       1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("031_e0",      1'b0, 1'b1, 8'hE0, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("031_74",      1'b0, 1'b1, 8'h74, 1'b0, 4'd2, 1'b1, 1'b1, 9'h002, 3'd1, 1'b0);
    add("031_e0b",     1'b0, 1'b1, 8'hE0, 1'b0, 4'd2, 1'b1, 1'b0, 9'h002, 3'd1, 1'b0);
    add("031_f0",      1'b0, 1'b1, 8'hF0, 1'b0, 4'd2, 1'b1, 1'b0, 9'h002, 3'd1, 1'b0);
    add("031_brk",     1'b0, 1'b1, 8'h74, 1'b0, 4'd2, 1'b1, 1'b0, 9'h000, 3'd1, 1'b0);
    add("031_idle",    1'b0, 1'b1, 8'h1C, 1'b0, 4'd2, 1'b1, 1'b1, 9'h001, 3'd2, 1'b0);
    add("031_pop",     1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b1, 1'b0, 9'h001, 3'd1, 1'b0);
    add("rst_b",       1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("032_16",      1'b0, 1'b1, 8'h16, 1'b0, 4'd7, 1'b1, 1'b1, 9'h040, 3'd1, 1'b0);
    add("032_1e",      1'b0, 1'b1, 8'h1E, 1'b0, 4'd7, 1'b1, 1'b1, 9'h0C0, 3'd2, 1'b0);
    add("032_26",      1'b0, 1'b1, 8'h26, 1'b0, 4'd7, 1'b1, 1'b1, 9'h1C0, 3'd3, 1'b0);
    add("032_29",      1'b0, 1'b1, 8'h29, 1'b0, 4'd7, 1'b1, 1'b1, 9'h1D0, 3'd4, 1'b0);
    add("032_drop",    1'b0, 1'b1, 8'h2D, 1'b0, 4'd7, 1'b1, 1'b1, 9'h1F0, 3'd4, 1'b1);
    add("032_pop1",    1'b0, 1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 9'h1F0, 3'd3, 1'b1);
    add("032_pop2",    1'b0, 1'b0, 8'h00, 1'b1, 4'd9, 1'b1, 1'b0, 9'h1F0, 3'd2, 1'b1);
    add("032_pop3",    1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b0, 9'h1F0, 3'd1, 1'b1);
    add("032_pop4",    1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 9'h1F0, 3'd0, 1'b1);
    add("rst_c",       1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("033_16",      1'b0, 1'b1, 8'h16, 1'b0, 4'd7, 1'b1, 1'b1, 9'h040, 3'd1, 1'b0);
    add("033_1e",      1'b0, 1'b1, 8'h1E, 1'b0, 4'd7, 1'b1, 1'b1, 9'h0C0, 3'd2, 1'b0);
    add("033_26",      1'b0, 1'b1, 8'h26, 1'b0, 4'd7, 1'b1, 1'b1, 9'h1C0, 3'd3, 1'b0);
    add("033_29",      1'b0, 1'b1, 8'h29, 1'b0, 4'd7, 1'b1, 1'b1, 9'h1D0, 3'd4, 1'b0);
    add("033_pushpop", 1'b0, 1'b1, 8'h72, 1'b1, 4'd8, 1'b1, 1'b1, 9'h1D8, 3'd4, 1'b0);
    add("033_pop1",    1'b0, 1'b0, 8'h00, 1'b1, 4'd9, 1'b1, 1'b0, 9'h1D8, 3'd3, 1'b0);
    add("033_pop2",    1'b0, 1'b0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b0, 9'h1D8, 3'd2, 1'b0);
    add("033_pop3",    1'b0, 1'b0, 8'h00, 1'b1, 4'd4, 1'b1, 1'b0, 9'h1D8, 3'd1, 1'b0);
    add("033_pop4",    1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 9'h1D8, 3'd0, 1'b0);
    add("rst_d",       1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("034_5a",      1'b0, 1'b1, 8'h5A, 1'b0, 4'd0, 1'b0, 1'b1, 9'h000, 3'd0, 1'b0);
    add("034_f0",      1'b0, 1'b1, 8'hF0, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("034_brk",     1'b0, 1'b1, 8'h5A, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("034_quiet",   1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("035_e0",      1'b0, 1'b1, 8'hE0, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("035_rst",     1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("035_6b",      1'b0, 1'b1, 8'h6B, 1'b0, 4'd1, 1'b1, 1'b1, 9'h001, 3'd1, 1'b0);
    add("rst_e",       1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("f0_pend",     1'b0, 1'b1, 8'hF0, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("f0_rst",      1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);
    add("f0_6b_make",  1'b0, 1'b1, 8'h6B, 1'b0, 4'd1, 1'b1, 1'b1, 9'h001, 3'd1, 1'b0);
    add("pushpop_lv1", 1'b0, 1'b1, 8'h72, 1'b1, 4'd4, 1'b1, 1'b1, 9'h009, 3'd1, 1'b0);
    add("rst_prio",    1'b1, 1'b1, 8'h1C, 1'b1, 4'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      rx_valid  = vecs[i].vld;
      rx_byte   = vecs[i].b;
      cmd_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check(vecs[i].name,
            {cmd_code, cmd_valid, any_make, held, level, overflow},
            {vecs[i].code, vecs[i].valid, vecs[i].any, vecs[i].held, vecs[i].lvl, vecs[i].ovf});
    end

    // Pointer wrap: repeated single push, then break with a simultaneous pop.
    reset = 1'b0; rx_valid = 1'b0; cmd_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rx_valid = 1'b1; rx_byte = keys[k % 3]; cmd_ready = 1'b0;
      @(posedge clk); #1;
      check("wrap_push", {cmd_code, cmd_valid, any_make, held & codes_mask(codes[k % 3]), level, overflow},
            {codes[k % 3], 1'b1, 1'b1, codes_mask(codes[k % 3]), 3'd1, 1'b0});
      rx_byte = 8'hF0;
      @(posedge clk); #1;
      rx_byte = keys[k % 3]; cmd_ready = 1'b1;
      @(posedge clk); #1;
      check("wrap_pop", {cmd_code, cmd_valid, any_make, held, level, overflow}, 19'd0);
    end
    rx_valid = 1'b0; cmd_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [8:0] codes_mask(input logic [3:0] c);
    logic [8:0] one;
    one = 9'd1;
    return one << (c - 4'd1);
  endfunction

endmodule

// File: doc/key_cmd_decoder.md
KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO depth in entries; power of two, 2..16.
REQ-002 Port: clk  input  1  single clock, all logic rising-edge; the 50 MHz keyboard domain.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on rising clk only.
REQ-004 Port: rx_byte  input  8  PS/2 byte from the byte receiver, valid only while rx_valid=1.
REQ-005 Port: rx_valid  input  1  one-cycle strobe, one per received byte.
REQ-006 Port: cmd_code  output  4  head-of-FIFO command; 1=L, 2=R, 3=U, 4=D, 5=PLACE, 6=ROT, 7=SEL1, 8=SEL2, 9=SEL3; 0 when empty.
REQ-007 Port: cmd_valid  output  1  FIFO non-empty.
REQ-008 Port: cmd_ready  input  1  consumer accepts the head entry when cmd_valid&&cmd_ready.
REQ-009 Port: any_make  output  1  one-cycle pulse per accepted make event (title-screen dismiss).
REQ-010 Port: held  output  9  per-command key-held mask; bit (code-1).
REQ-011 Port: level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 Port: overflow  output  1  sticky; set when a command is dropped.

Function
REQ-013 Parser FSM states: S_IDLE, S_EXT, S_BRK; advances only on rx_valid=1.
REQ-014 S_IDLE: E0 -> S_EXT; F0 -> S_BRK; any other byte -> make event, stay S_IDLE.
REQ-015 S_EXT: E0 -> S_EXT; F0 -> S_BRK; any other byte -> make event, -> S_IDLE.
REQ-016 S_BRK: any byte other than E0/F0 -> break event, -> S_IDLE; E0 or F0 -> stay S_BRK, no event.
REQ-017 Byte-to-command map ignores the extended flag: 6B/1C->L, 74/23->R, 75/1D->U, 72/1B->D, 29->PLACE, 2D->ROT, 16->SEL1, 1E->SEL2, 26->SEL3; any other byte is unmapped.
REQ-018 Mapped make with held bit clear: set held bit; push code; pulse any_make.
REQ-019 Mapped make with held bit set (typematic repeat): no push, no any_make, held unchanged.
REQ-020 Unmapped make: pulse any_make only; no push; held unchanged.
REQ-021 Break of a mapped key: clear its held bit, no push; unmapped break: no effect.
REQ-022 Latency: rx_valid at edge N -> held, any_make, level and FIFO write visible after edge N+1; with the FIFO empty, cmd_valid=1 with the new code in that same cycle.
REQ-023 Pop: cmd_valid&&cmd_ready at an edge removes the head; cmd_ready while empty has no effect.
REQ-024 Push and pop in the same cycle: both occur; level unchanged; no overflow, including when full.
REQ-025 Push while full without pop: command dropped; overflow set; held bit still set per REQ-018.
REQ-026 FIFO order is strict FIFO; read and write pointers wrap modulo DEPTH; level never exceeds DEPTH.
REQ-027 cmd_code, cmd_valid, level and any_make are registered outputs with no combinational path from inputs.

Reset
REQ-028 reset=1 at an edge: FSM -> S_IDLE; FIFO emptied (level=0, cmd_valid=0, cmd_code=0); held=0; any_make=0; overflow=0.
REQ-029 reset has priority over rx_valid and cmd_ready in the same cycle; a partially parsed E0/F0 sequence is discarded.

Verification
REQ-030 Bytes 1C, then 1C, then F0 1C, then 1C, cmd_ready=0 -> two entries of code 1; any_make pulses twice; held[0] sequence 1,1,0,1.
REQ-031 Bytes E0 74, then E0 F0 74 -> one push of code 2; held[1] set, then cleared; FSM returns to S_IDLE.
REQ-032 Distinct mapped makes 16,1E,26,29,2D with DEPTH=4, cmd_ready=0 -> level=4, codes 7,8,9,5 queued; overflow=1; held bits 6,7,8,4,5 all set.
REQ-033 FIFO full, cmd_ready=1 and new make 72 in the same cycle -> head popped, code 4 appended; level stays 4; overflow stays 0.
REQ-034 Unmapped byte 5A -> any_make pulses one cycle, level=0; then F0 5A -> no any_make and no other output change.
REQ-035 Byte E0, then reset asserted for one cycle, then byte 6B -> level=0 after reset; the 6B is treated as a normal make, push code 1.
